// File: rtl/dsram_arbiter_if.sv
// dsram_arbiter_if
//   Bundles the two requester ports and the SRAM port of the data-SRAM
//   arbiter.
//   m0_* : EXU load/store port (req, addr, re, we, wdata -> gnt, rvalid, rdata)
//   m1_* : secondary master, debug/DMA fill (same signal set as m0)
//   sram_*: single-port SRAM side (en, we, addr, wdata -> rdata)
//   Modports:
//     slave  : the arbiter (sees requests, drives grants/read data/SRAM)
//     master : the environment (requesters plus SRAM model)
interface dsram_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [3:0]  m0_re;
  logic [3:0]  m0_we;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [3:0]  m1_re;
  logic [3:0]  m1_we;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_re, m0_we, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_re, m1_we, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_re, m0_we, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_re, m1_we, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/dsram_arbiter.sv
// dsram_arbiter
//   Shares the single-port data SRAM between the EXU (port 0) and a
//   secondary master (port 1). Port 0 has fixed priority; a saturating
//   starvation counter hands priority to port 1 after STARVE_MAX consecutive
//   denied cycles. Grants are combinational; read data returns one cycle
//   after the grant and is steered to the port that owned the access.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous, active-low reset
//     bus : dsram_arbiter_if.slave (requester ports and SRAM port)
//   Parameters:
//     STARVE_MAX : denied cycles of port 1 before it takes priority (1..15)
//     CW         : starvation counter width, must hold STARVE_MAX
module dsram_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CW         = 4
) (
  input logic            clk,
  input logic            rst,
  dsram_arbiter_if.slave bus
);

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic          q0;
  logic          q1;
  logic          gnt0;
  logic          gnt1;
  logic          rd_gnt;
  logic [CW-1:0] starve_cnt;
  logic          rd_pend;
  logic          rd_owner;

  // A request with no strobes at all is not an access and is ignored.
  always_comb begin
    q0   = bus.m0_req & ((bus.m0_re | bus.m0_we) != 4'b0000);
    q1   = bus.m1_req & ((bus.m1_re | bus.m1_we) != 4'b0000);
    gnt1 = q1 & (~q0 | (starve_cnt == STARVE_LIM));
    gnt0 = q0 & ~gnt1;
  end

  always_comb begin
    bus.m0_gnt = gnt0;
    bus.m1_gnt = gnt1;
  end

  // Write strobes win over read strobes, so a granted access is a read only
  // when the winner's we is all zero.
  always_comb begin
    rd_gnt = (gnt0 & (bus.m0_we == 4'b0000)) | (gnt1 & (bus.m1_we == 4'b0000));
  end

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    if (gnt1) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.m1_we;
      bus.sram_addr  = bus.m1_addr;
      bus.sram_wdata = bus.m1_wdata;
    end else if (gnt0) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.m0_we;
      bus.sram_addr  = bus.m0_addr;
      bus.sram_wdata = bus.m0_wdata;
    end
  end

  // Counts consecutive cycles port 1 was qualified but lost; any cycle it is
  // idle or served starts the count over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (gnt1 || !q1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= rd_gnt;
      rd_owner <= gnt1;
    end
  end

  always_comb begin
    bus.m0_rvalid = rd_pend & ~rd_owner;
    bus.m1_rvalid = rd_pend & rd_owner;
    bus.m0_rdata  = bus.m0_rvalid ? bus.sram_rdata : 32'h0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.sram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dsram_arbiter.sv
module tb_dsram_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dsram_arbiter_if bus ();

  dsram_arbiter #(.STARVE_MAX(STARVE_MAX), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: how many cycles in a row port 1 has been turned away,
  // and the owner of an outstanding read (-1 when none).
  int m_denied;
  int m_owner;

  function automatic bit qual(input logic req, input logic [3:0] re, input logic [3:0] we);
    return req && ((re | we) != 0);
  endfunction

  // Returns winner id 0/1, or -1 when nobody is served this cycle.
  function automatic int winner();
    bit a, b;
    a = qual(bus.m0_req, bus.m0_re, bus.m0_we);
    b = qual(bus.m1_req, bus.m1_re, bus.m1_we);
    if (b && (!a || m_denied >= STARVE_MAX)) return 1;
    if (a) return 0;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_denied <= 0;
      m_owner  <= -1;
    end else begin
      w = winner();
      if (qual(bus.m1_req, bus.m1_re, bus.m1_we) && w != 1)
        m_denied <= (m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1;
      else
        m_denied <= 0;
      if (w == 0 && bus.m0_we == 0) m_owner <= 0;
      else if (w == 1 && bus.m1_we == 0) m_owner <= 1;
      else m_owner <= -1;
    end
  end

  always @(negedge clk) begin
    int w;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd;
    w = winner();
    e_we = 0; e_addr = 0; e_wd = 0;
    if (w == 0) begin e_we = bus.m0_we; e_addr = bus.m0_addr; e_wd = bus.m0_wdata; end
    if (w == 1) begin e_we = bus.m1_we; e_addr = bus.m1_addr; e_wd = bus.m1_wdata; end
    chk("cmp_m0_gnt", 32'(bus.m0_gnt), 32'(w == 0));
    chk("cmp_m1_gnt", 32'(bus.m1_gnt), 32'(w == 1));
    chk("cmp_sram_en", 32'(bus.sram_en), 32'(w >= 0));
    chk("cmp_sram_we", 32'(bus.sram_we), 32'(e_we));
    chk("cmp_sram_addr", bus.sram_addr, e_addr);
    chk("cmp_sram_wdata", bus.sram_wdata, e_wd);
    chk("cmp_m0_rvalid", 32'(bus.m0_rvalid), 32'(m_owner == 0));
    chk("cmp_m1_rvalid", 32'(bus.m1_rvalid), 32'(m_owner == 1));
    chk("cmp_m0_rdata", bus.m0_rdata, (m_owner == 0) ? bus.sram_rdata : 32'h0);
    chk("cmp_m1_rdata", bus.m1_rdata, (m_owner == 1) ? bus.sram_rdata : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic [31:0] addr, input logic [3:0] re,
                        input logic [3:0] we, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_addr = addr; bus.m0_re = re; bus.m0_we = we; bus.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic [31:0] addr, input logic [3:0] re,
                        input logic [3:0] we, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_addr = addr; bus.m1_re = re; bus.m1_we = we; bus.m1_wdata = wdata;
  endtask

  task automatic idle();
    set_m0(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    set_m1(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    idle();
    bus.sram_rdata = 32'h0;
    tick();
    #2;
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    chk("rst_sram_en", 32'(bus.sram_en), 32'h0);
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
    tick();
    rst = 1'b1;

    // Single read from port 0
    tick();
    set_m0(1'b1, 32'h100, 4'hF, 4'h0, 32'h0);
    #2;
    chk("rd_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    chk("rd_sram_en", 32'(bus.sram_en), 32'h1);
    chk("rd_sram_we", 32'(bus.sram_we), 32'h0);
    chk("rd_sram_addr", bus.sram_addr, 32'h100);
    tick();
    idle();
    bus.sram_rdata = 32'hDEADBEEF;
    #2;
    chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);

    // Port 1 write, no read data follows
    tick();
    set_m1(1'b1, 32'h200, 4'h0, 4'b0100, 32'h00AB0000);
    #2;
    chk("wr_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    chk("wr_sram_we", 32'(bus.sram_we), 32'h4);
    chk("wr_sram_wdata", bus.sram_wdata, 32'h00AB0000);
    tick();
    idle();
    #2;
    chk("wr_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    chk("wr_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);

    // Contention: port 1 gets the slot on the fifth cycle only
    for (int i = 0; i < 6; i++) begin
      tick();
      set_m0(1'b1, 32'h10 + 32'(i), 4'hF, 4'h0, 32'h0);
      set_m1(1'b1, 32'h20, 4'hF, 4'h0, 32'h0);
      bus.sram_rdata = 32'h1000 + 32'(i);
      #2;
      chk("cont_m1_gnt", 32'(bus.m1_gnt), 32'(i == 4));
      chk("cont_m0_gnt", 32'(bus.m0_gnt), 32'(i != 4));
    end

    // Interleaved reads, data must reach the owner only
    tick();
    set_m0(1'b1, 32'h30, 4'hF, 4'h0, 32'h0);
    set_m1(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    tick();
    set_m0(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    set_m1(1'b1, 32'h40, 4'h3, 4'h0, 32'h0);
    bus.sram_rdata = 32'hAAAA0000;
    #2;
    chk("il_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("il_m0_rdata", bus.m0_rdata, 32'hAAAA0000);
    chk("il_m1_rvalid_early", 32'(bus.m1_rvalid), 32'h0);
    tick();
    idle();
    bus.sram_rdata = 32'h5555BBBB;
    #2;
    chk("il_m1_rvalid", 32'(bus.m1_rvalid), 32'h1);
    chk("il_m1_rdata", bus.m1_rdata, 32'h5555BBBB);
    chk("il_m0_rdata", bus.m0_rdata, 32'h0);

    // Null request on port 0 does not block port 1
    for (int i = 0; i < 2; i++) begin
      tick();
      set_m0(1'b1, 32'h50, 4'h0, 4'h0, 32'h0);
      set_m1(1'b1, 32'h60, 4'hF, 4'h0, 32'h0);
      #2;
      chk("null_m1_gnt", 32'(bus.m1_gnt), 32'h1);
      chk("null_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    end
    tick();
    idle();
    chk("null_starve", 32'(dut.starve_cnt), 32'h0);

    // Read followed by write, plus both strobe sets treated as a write
    tick();
    set_m0(1'b1, 32'h70, 4'hF, 4'h0, 32'h0);
    tick();
    set_m0(1'b1, 32'h74, 4'hF, 4'h3, 32'h12345678);
    bus.sram_rdata = 32'hCAFEF00D;
    #2;
    chk("rw_sram_we", 32'(bus.sram_we), 32'h3);
    chk("rw_m0_rdata", bus.m0_rdata, 32'hCAFEF00D);
    tick();
    idle();
    #2;
    chk("rw_no_rvalid", 32'(bus.m0_rvalid), 32'h0);

    // Reset while a read is pending and the starve counter is nonzero
    for (int i = 0; i < 2; i++) begin
      tick();
      set_m0(1'b1, 32'h80, 4'hF, 4'h0, 32'h0);
      set_m1(1'b1, 32'h90, 4'hF, 4'h0, 32'h0);
    end
    tick();
    idle();
    bus.sram_rdata = 32'h0BADCAFE;
    #1;
    chk("pre_rst_rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("pre_rst_starve", 32'(dut.starve_cnt), 32'h2);
    rst = 1'b0;
    #1;
    chk("arst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    chk("arst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("arst_starve", 32'(dut.starve_cnt), 32'h0);
    tick();
    rst = 1'b1;

    // Starve count restarts from zero after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      set_m0(1'b1, 32'hA0, 4'hF, 4'h0, 32'h0);
      set_m1(1'b1, 32'hB0, 4'h0, 4'hF, 32'hFFFF0000);
      #2;
      chk("post_rst_m1_gnt", 32'(bus.m1_gnt), 32'(i == 4));
    end
    tick();
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
Shares the single-port data SRAM between two requesters. Port 0 is the EXU load/store path (addr/re/we/wdata). Port 1 is a secondary master (debug/DMA fill). Fixed priority goes to port 0, with a starvation counter that guarantees port 1 forward progress. Read data returns one cycle after grant and is routed back to the requester that owned the access.

Parameters:
STARVE_MAX, 4, consecutive denied cycles of port 1 before it takes priority; legal 1..15
CW, 4, starvation counter width; must hold STARVE_MAX

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
m0_req  in  1  EXU request valid
m0_addr  in  32  EXU byte address
m0_re  in  4  EXU read byte strobes
m0_we  in  4  EXU write byte strobes
m0_wdata  in  32  EXU write data, already lane-aligned
m0_gnt  out  1  EXU request accepted this cycle
m0_rvalid  out  1  EXU read data valid
m0_rdata  out  32  EXU read data
m1_req  in  1  port 1 request valid
m1_addr  in  32  port 1 byte address
m1_re  in  4  port 1 read strobes
m1_we  in  4  port 1 write strobes
m1_wdata  in  32  port 1 write data
m1_gnt  out  1  port 1 accepted
m1_rvalid  out  1  port 1 read data valid
m1_rdata  out  32  port 1 read data
sram_en  out  1  SRAM access enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  32  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid 1 cycle after read enable

Behaviour:
- Qualified request: mN_req & ((mN_re|mN_we)!=0). A request with both strobe sets zero is ignored: no gnt, no access.
- Operation type: write if mN_we!=0 (we wins when both strobe sets are nonzero); otherwise read.
- Requester holds req/addr/strobes/wdata stable until its gnt; the arbiter does not buffer requests.
- Grant is combinational, same cycle. At most one gnt per cycle.
- Priority: port 0 wins unless starve_cnt==STARVE_MAX, in which case port 1 wins when qualified.
- Winner drives sram_addr, sram_wdata and sram_we (sram_we = winner we on writes, 0 on reads); sram_en=1. With no winner: sram_en=0, sram_we=0, addr/wdata=0.
- starve_cnt, CW bits, registered:
  - clears to 0 on an m1 grant, or when m1 is not qualified;
  - increments when m1 is qualified and denied;
  - saturates at STARVE_MAX.
- Read return pipeline, registered:
  - rd_pend <= read granted this cycle; rd_owner <= winner id.
  - Next cycle: mN_rvalid = rd_pend & (rd_owner==N); mN_rdata = sram_rdata when own rvalid, else 0.
- Back-to-back reads from either port are accepted every cycle; throughput is 1 access/cycle.
- A write following a read is granted normally; read data for the earlier read is still delivered.
- Reset (rst low, async): starve_cnt=0, rd_pend=0, rd_owner=0; all rvalid=0, all rdata=0.
- gnt and sram_* are combinational from inputs and follow reset state (0 while requests are low).
- Reset asserted the cycle after a read grant drops the pending rvalid; that read is lost and the requester must reissue.
- Reset deassertion is synchronised upstream; the arbiter is live from the first rising edge with rst high.

Test Plan:
- Reset: drive rst low mid-run with rd_pend=1 -> m0_rvalid=m1_rvalid=0 and starve_cnt=0 immediately, without waiting for a clock edge.
- Single read: m0_req=1, m0_re=4'b1111, addr=0x100, SRAM returns 0xDEADBEEF -> same-cycle m0_gnt=1 and sram_en=1, sram_we=0; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Contention, port 0 wins: both ports request continuously -> m0 granted cycles 0..3; starve_cnt reaches 4; cycle 4 grants m1; starve_cnt returns to 0; cycle 5 grants m0.
- Port 1 write: m1 only, we=4'b0100, wdata=0x00AB0000 -> m1_gnt=1, sram_we=4'b0100, sram_wdata=0x00AB0000; no rvalid follows.
- Interleaved reads: m0 read, then m1 read on consecutive cycles -> rvalid arrives one cycle after each grant and goes to the correct owner; data is never cross-routed.
- Null request: m0_req=1 with re=we=0 while m1 reads -> m1 granted; m0_gnt=0; starve_cnt stays 0.
